// File: rtl/hs32_memresp.sv
// hs32_memresp: word-addressed on-chip RAM serving the hs32 reqm/rdym handshake.
// One read or write per request, WAIT wait states before a one-cycle rdym;
// out-of-range and misaligned accesses complete with fault so the initiator never stalls.
// Optional: define HS32_MEMRESP_WPROT_EN to write-protect word indices below ROMWORDS.
module hs32_memresp #(
  parameter int          AW       = 10,
  parameter int          WAIT     = 1,
  parameter int unsigned ROMWORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] dtwm,
  output logic [31:0] dtrm,
  input  logic        reqm,
  input  logic        rw_mem,
  output logic        rdym,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          rw_q;
  logic [31:0]   mem [2**AW];

  logic [31:0]   a_eff;
  logic [31:0]   d_eff;
  logic          rw_eff;
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          misaligned;
  logic          wprot;
  logic          reject;
  logic          accept;
  logic          go_ack;
  logic          we;

  // Access operands: with WAIT=0 the access lands on the accepting edge, so IDLE uses the live inputs
  always_comb begin
    a_eff  = addr_q;
    d_eff  = data_q;
    rw_eff = rw_q;
    if (state == IDLE) begin
      a_eff  = addr;
      d_eff  = dtwm;
      rw_eff = rw_mem;
    end
  end

  assign idx          = a_eff[AW+1:2];
  assign out_of_range = |a_eff[31:AW+2];
  assign misaligned   = |a_eff[1:0];

`ifdef HS32_MEMRESP_WPROT_EN
  assign wprot = rw_eff && (32'(idx) < ROMWORDS);
`else
  // Protection disabled: term is constant zero, ROMWORDS has no effect
  assign wprot = 1'b0 && (32'(idx) < ROMWORDS);
`endif

  assign reject = out_of_range || misaligned || wprot;
  assign accept = (state == IDLE) && reqm;
  assign go_ack = (state_nx == ACK);
  assign we     = go_ack && rw_eff && !reject && !reset;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; reqm is only looked at in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (reqm) begin
          state_nx = (WAIT_CNT == '0) ? ACK : BUSY;
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rw_q   <= 1'b0;
      rdym   <= 1'b0;
      fault  <= 1'b0;
      dtrm   <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        data_q <= dtwm;
        rw_q   <= rw_mem;
        cnt    <= WAIT_CNT;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      rdym  <= go_ack;
      fault <= go_ack && reject;
      if (go_ack) begin
        if (reject) begin
          dtrm <= '0;
        end else if (!rw_eff) begin
          dtrm <= mem[idx];
        end
      end
    end
  end

  // RAM write port; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= d_eff;
    end
  end

endmodule

// File: tb/tb_hs32_memresp.sv
// Bench for hs32_memresp: four instances with WAIT = 0..3 (instance index = WAIT).
module tb_hs32_memresp;

  localparam int NI = 4;
  localparam int AW = 10;
`ifdef HS32_MEMRESP_WPROT_EN
  localparam logic [31:0] OFS = 32'h800;
`else
  localparam logic [31:0] OFS = 32'h0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        eflt;
    logic [31:0] edt;
  } op_t;

  typedef struct {
    int          lat;
    logic        flt;
    logic [31:0] dt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr   [NI];
  logic [31:0] dtwm   [NI];
  logic [31:0] dtrm   [NI];
  logic        reqm   [NI];
  logic        rw_mem [NI];
  logic        rdym   [NI];
  logic        fault  [NI];

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hs32_memresp #(.AW(AW), .WAIT(0), .ROMWORDS(256)) u_w0 (
    .clk(clk), .reset(reset), .addr(addr[0]), .dtwm(dtwm[0]), .dtrm(dtrm[0]),
    .reqm(reqm[0]), .rw_mem(rw_mem[0]), .rdym(rdym[0]), .fault(fault[0]));
  hs32_memresp #(.AW(AW), .WAIT(1), .ROMWORDS(256)) u_w1 (
    .clk(clk), .reset(reset), .addr(addr[1]), .dtwm(dtwm[1]), .dtrm(dtrm[1]),
    .reqm(reqm[1]), .rw_mem(rw_mem[1]), .rdym(rdym[1]), .fault(fault[1]));
  hs32_memresp #(.AW(AW), .WAIT(2), .ROMWORDS(256)) u_w2 (
    .clk(clk), .reset(reset), .addr(addr[2]), .dtwm(dtwm[2]), .dtrm(dtrm[2]),
    .reqm(reqm[2]), .rw_mem(rw_mem[2]), .rdym(rdym[2]), .fault(fault[2]));
  hs32_memresp #(.AW(AW), .WAIT(3), .ROMWORDS(256)) u_w3 (
    .clk(clk), .reset(reset), .addr(addr[3]), .dtwm(dtwm[3]), .dtrm(dtrm[3]),
    .reqm(reqm[3]), .rw_mem(rw_mem[3]), .rdym(rdym[3]), .fault(fault[3]));

  // Drives one request on instance k, waits (bounded) for rdym, then one more edge.
  // lat counts edges from the accepting edge (1) to the edge after which rdym is seen.
  task automatic do_access(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic w, output int lat, output logic flt,
                           output logic [31:0] dt, output logic after);
    lat   = 0;
    flt   = 1'bx;
    dt    = 'x;
    addr[k]   = a;
    dtwm[k]   = d;
    rw_mem[k] = w;
    reqm[k]   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdym[k]) begin
        lat = i;
        flt = fault[k];
        dt  = dtrm[k];
        break;
      end
    end
    reqm[k] = 1'b0;
    @(posedge clk); #1;
    after = rdym[k];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      reqm[k] = 1'b0; rw_mem[k] = 1'b0; addr[k] = '0; dtwm[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdym[k] !== 1'b0) begin errors++; $display("FAIL reset_rdym[%0d]: got %b want 0", k, rdym[k]); end
      checks++;
      if (fault[k] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d]: got %b want 0", k, fault[k]); end
      checks++;
      if (dtrm[k] !== 32'h0) begin errors++; $display("FAIL reset_dtrm[%0d]: got %h want 0", k, dtrm[k]); end
    end
  endtask

  task automatic test_write_read();
    op_t ops [2];
    exp_t e;
    int lat; logic flt, after; logic [31:0] dt;
    ops[0] = '{a: 32'h400, d: 32'hDEADBEEF, w: 1'b1, eflt: 1'b0, edt: 32'h0};
    ops[1] = '{a: 32'h400, d: 32'h0,        w: 1'b0, eflt: 1'b0, edt: 32'hDEADBEEF};
    foreach (ops[i]) begin
      e = '{lat: 2, flt: ops[i].eflt, dt: ops[i].edt};
      sb.push_back(e);
      do_access(1, ops[i].a, ops[i].d, ops[i].w, lat, flt, dt, after);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL wr_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (flt !== e.flt) begin errors++; $display("FAIL wr_fault[%0d]: got %b want %b", i, flt, e.flt); end
      checks++;
      if (dt !== e.dt) begin errors++; $display("FAIL wr_dtrm[%0d]: got %h want %h", i, dt, e.dt); end
      checks++;
      if (after !== 1'b0) begin errors++; $display("FAIL wr_pulse[%0d]: rdym got %b want 0", i, after); end
    end
  endtask

  task automatic test_reject();
    op_t ops [7];
    exp_t e;
    int lat; logic flt, after; logic [31:0] dt;
    ops[0] = '{a: 32'h00001000, d: 32'h0,  w: 1'b0, eflt: 1'b1, edt: 32'h0};
    ops[1] = '{a: 32'h00000400, d: 32'h0,  w: 1'b0, eflt: 1'b0, edt: 32'hDEADBEEF};
    ops[2] = '{a: 32'h00000402, d: 32'h55, w: 1'b1, eflt: 1'b1, edt: 32'h0};
    ops[3] = '{a: 32'h00000400, d: 32'h0,  w: 1'b0, eflt: 1'b0, edt: 32'hDEADBEEF};
    ops[4] = '{a: 32'h00000003, d: 32'h0,  w: 1'b0, eflt: 1'b1, edt: 32'h0};
    ops[5] = '{a: 32'h80000000, d: 32'h1,  w: 1'b1, eflt: 1'b1, edt: 32'h0};
    ops[6] = '{a: 32'h00000400, d: 32'h0,  w: 1'b0, eflt: 1'b0, edt: 32'hDEADBEEF};
    foreach (ops[i]) begin
      e = '{lat: 2, flt: ops[i].eflt, dt: ops[i].edt};
      sb.push_back(e);
      do_access(1, ops[i].a, ops[i].d, ops[i].w, lat, flt, dt, after);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL rej_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (flt !== e.flt) begin errors++; $display("FAIL rej_fault[%0d]: got %b want %b", i, flt, e.flt); end
      checks++;
      if (dt !== e.dt) begin errors++; $display("FAIL rej_dtrm[%0d]: got %h want %h", i, dt, e.dt); end
      checks++;
      if (after !== 1'b0) begin errors++; $display("FAIL rej_pulse[%0d]: rdym got %b want 0", i, after); end
    end
  endtask

  task automatic test_wprot();
    op_t ops [2];
    exp_t e;
    int lat; logic flt, after; logic [31:0] dt, prev;
`ifdef HS32_MEMRESP_WPROT_EN
    logic [31:0] old;
    do_access(1, 32'h10, 32'h0, 1'b0, lat, flt, old, after);
    do_access(1, 32'h10, 32'h12345678, 1'b1, lat, flt, dt, after);
    checks++;
    if (flt !== 1'b1) begin errors++; $display("FAIL wprot_fault: got %b want 1", flt); end
    checks++;
    if (dt !== 32'h0) begin errors++; $display("FAIL wprot_dtrm: got %h want 0", dt); end
    do_access(1, 32'h10, 32'h0, 1'b0, lat, flt, dt, after);
    checks++;
    if (dt !== old) begin errors++; $display("FAIL wprot_keep: got %h want %h", dt, old); end
    checks++;
    if (flt !== 1'b0) begin errors++; $display("FAIL wprot_read_fault: got %b want 0", flt); end
    prev = old;
`else
    do_access(1, 32'h10, 32'h12345678, 1'b1, lat, flt, dt, after);
    checks++;
    if (flt !== 1'b0) begin errors++; $display("FAIL nowprot_fault: got %b want 0", flt); end
    checks++;
    if (dt !== 32'hDEADBEEF) begin errors++; $display("FAIL nowprot_dtrm: got %h want deadbeef", dt); end
    do_access(1, 32'h10, 32'h0, 1'b0, lat, flt, dt, after);
    checks++;
    if (dt !== 32'h12345678) begin errors++; $display("FAIL nowprot_commit: got %h want 12345678", dt); end
    prev = 32'h12345678;
`endif
    ops[0] = '{a: 32'h400, d: 32'h12345678, w: 1'b1, eflt: 1'b0, edt: prev};
    ops[1] = '{a: 32'h400, d: 32'h0,        w: 1'b0, eflt: 1'b0, edt: 32'h12345678};
    foreach (ops[i]) begin
      e = '{lat: 2, flt: ops[i].eflt, dt: ops[i].edt};
      sb.push_back(e);
      do_access(1, ops[i].a, ops[i].d, ops[i].w, lat, flt, dt, after);
      e = sb.pop_front();
      checks++;
      if (flt !== e.flt) begin errors++; $display("FAIL hi_fault[%0d]: got %b want %b", i, flt, e.flt); end
      checks++;
      if (dt !== e.dt) begin errors++; $display("FAIL hi_dtrm[%0d]: got %h want %h", i, dt, e.dt); end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops [2];
    exp_t e;
    int lat; logic flt, after; logic [31:0] dt;
    logic [4:0]  exp_r;
    logic [31:0] exp_d [5];
    ops[0] = '{a: OFS,         d: 32'hA0A0A0A0, w: 1'b1, eflt: 1'b0, edt: 32'h0};
    ops[1] = '{a: OFS + 32'h4, d: 32'hB4B4B4B4, w: 1'b1, eflt: 1'b0, edt: 32'h0};
    foreach (ops[i]) begin
      e = '{lat: 1, flt: ops[i].eflt, dt: ops[i].edt};
      sb.push_back(e);
      do_access(0, ops[i].a, ops[i].d, ops[i].w, lat, flt, dt, after);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL w0_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (flt !== e.flt) begin errors++; $display("FAIL w0_fault[%0d]: got %b want %b", i, flt, e.flt); end
    end
    // reqm held high: accepted, ACK (ignored), accepted, ACK, then idle
    exp_r = 5'b00101;
    exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'h0; exp_d[2] = 32'hB4B4B4B4;
    exp_d[3] = 32'h0;        exp_d[4] = 32'h0;
    addr[0] = OFS; rw_mem[0] = 1'b0; reqm[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rdym[0] !== exp_r[i]) begin errors++; $display("FAIL b2b_rdym[%0d]: got %b want %b", i, rdym[0], exp_r[i]); end
      if (exp_r[i]) begin
        checks++;
        if (dtrm[0] !== exp_d[i]) begin errors++; $display("FAIL b2b_dtrm[%0d]: got %h want %h", i, dtrm[0], exp_d[i]); end
      end
      if (i == 0) addr[0] = OFS + 32'h4;
      if (i == 2) reqm[0] = 1'b0;
    end
  endtask

  task automatic test_abort();
    int lat, extra; logic flt, after; logic [31:0] dt;
    lat = 0; flt = 1'bx; extra = 0;
    addr[2] = OFS + 32'h20; dtwm[2] = 32'hCAFEF00D; rw_mem[2] = 1'b1; reqm[2] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) reqm[2] = 1'b0;
      if (rdym[2]) begin lat = i; flt = fault[2]; break; end
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL abort_latency: got %0d want 3", lat); end
    checks++;
    if (flt !== 1'b0) begin errors++; $display("FAIL abort_fault: got %b want 0", flt); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rdym[2]) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL abort_extra_pulses: got %0d want 0", extra); end
    do_access(2, OFS + 32'h20, 32'h0, 1'b0, lat, flt, dt, after);
    checks++;
    if (dt !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_commit: got %h want cafef00d", dt); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL abort_read_latency: got %0d want 3", lat); end
  endtask

  task automatic test_reset_busy();
    int lat, seen; logic flt, after; logic [31:0] dt;
    do_access(3, OFS + 32'h8, 32'h11111111, 1'b1, lat, flt, dt, after);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL w3_latency: got %0d want 4", lat); end
    do_access(3, OFS + 32'h8, 32'h0, 1'b0, lat, flt, dt, after);
    checks++;
    if (dt !== 32'h11111111) begin errors++; $display("FAIL w3_read: got %h want 11111111", dt); end
    addr[3] = OFS + 32'h8; dtwm[3] = 32'h22222222; rw_mem[3] = 1'b1; reqm[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    reqm[3] = 1'b0;
    #1;
    checks++;
    if (dtrm[3] !== 32'h0) begin errors++; $display("FAIL rstbusy_async_dtrm: got %h want 0", dtrm[3]); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) reset = 1'b0;
      if (rdym[3]) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstbusy_ack: got %0d pulses want 0", seen); end
    checks++;
    if (rdym[3] !== 1'b0) begin errors++; $display("FAIL rstbusy_rdym: got %b want 0", rdym[3]); end
    checks++;
    if (fault[3] !== 1'b0) begin errors++; $display("FAIL rstbusy_fault: got %b want 0", fault[3]); end
    checks++;
    if (dtrm[3] !== 32'h0) begin errors++; $display("FAIL rstbusy_dtrm: got %h want 0", dtrm[3]); end
    do_access(3, OFS + 32'h8, 32'h0, 1'b0, lat, flt, dt, after);
    checks++;
    if (dt !== 32'h11111111) begin errors++; $display("FAIL rstbusy_keep: got %h want 11111111", dt); end
    checks++;
    if (flt !== 1'b0) begin errors++; $display("FAIL rstbusy_read_fault: got %b want 0", flt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reject();
    test_wprot();
    test_back_to_back();
    test_abort();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
